// File: rtl/ball_loop_automaton.sv
// -----------------------------------------------------------------------------
// ball_loop_automaton
//
// Location automaton that runs a nested X/Y/Z/W loop program. It is a
// closed-system verification benchmark, so there is no datapath I/O. A one-hot
// program counter `loc` covers locations L0..L8:
//   * L7 is the error location (the assertion target).
//   * L8 is the exit and idle location.
// The block also provides a start handshake, a saturating back-edge counter
// and a sticky one-hot integrity monitor.
//
// Parameters
//   W       data width of x, y, z, w (all arithmetic wraps mod 2^W)
//   STEP    increment applied to x in L2 (a multiple of 2^W makes L7 reachable)
//   Y_STEP  increment applied to y in L0 (0 keeps y frozen)
//   MAX_IT  saturation value of iter_cnt
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   launch request; accepted only when done & !err & onehot_ok
//   y_init     in   value loaded into y on an accepted start
//   w_init     in   value loaded into w on an accepted start
//   inj_loc    in   fault-injection hook, XORed into loc on every write (tie 0)
//   loc        out  location register, bit i = Li
//   x, y, z    out  program variables
//   err        out  loc[7], sticky until reset
//   done       out  loc[8]
//   busy       out  neither error nor exit location active
//   onehot_ok  out  registered one-hot check of loc (one cycle late)
//   iter_cnt   out  count of L5->L1 back-edges, saturating at MAX_IT
//   iter_sat   out  iter_cnt == MAX_IT
// -----------------------------------------------------------------------------
module ball_loop_automaton #(
  parameter int W      = 3,
  parameter int STEP   = 1,
  parameter int Y_STEP = 0,
  parameter int MAX_IT = 15,
  localparam int ITW   = $clog2(MAX_IT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   y_init,
  input  logic [W-1:0]   w_init,
  input  logic [8:0]     inj_loc,
  output logic [8:0]     loc,
  output logic [W-1:0]   x,
  output logic [W-1:0]   y,
  output logic [W-1:0]   z,
  output logic           err,
  output logic           done,
  output logic           busy,
  output logic           onehot_ok,
  output logic [ITW-1:0] iter_cnt,
  output logic           iter_sat
);

  // Location indices into the one-hot register.
  typedef enum logic [3:0] {
    L0 = 4'd0, L1 = 4'd1, L2 = 4'd2, L3 = 4'd3, L4 = 4'd4,
    L5 = 4'd5, L6 = 4'd6, L7 = 4'd7, L8 = 4'd8
  } loc_idx_e;

  localparam logic [W-1:0]   STEP_W   = W'(STEP);
  localparam logic [W-1:0]   Y_STEP_W = W'(Y_STEP);
  localparam logic [ITW-1:0] MAX_IT_W = ITW'(MAX_IT);
  localparam logic [8:0]     LOC_IDLE = 9'h100;
  localparam logic [8:0]     LOC_L0   = 9'h001;

  logic [W-1:0]   w;
  logic [8:0]     loc_next;
  logic [8:0]     loc_adv;
  logic [W-1:0]   x_next;
  logic [W-1:0]   y_next;
  logic [W-1:0]   z_next;
  logic [W-1:0]   w_next;
  logic [ITW-1:0] iter_next;
  logic           start_ok;
  logic           x_eq_y;
  logic           w_nz;
  logic           z_nz;
  logic           back_edge;

  assign x_eq_y    = (x == y);
  assign w_nz      = (w != '0);
  assign z_nz      = (z != '0);
  assign back_edge = loc[L5] & ~x_eq_y;
  assign start_ok  = start & loc[L8] & ~loc[L7] & onehot_ok;

  assign err      = loc[L7];
  assign done     = loc[L8];
  assign busy     = ~(loc[L7] | loc[L8]);
  assign iter_sat = (iter_cnt == MAX_IT_W);

  // Each bit of the next location is an OR of its predecessor edges. This
  // keeps the transition well defined even when loc is not one-hot: several
  // active bits each contribute their own successors.
  always_comb begin
    loc_adv     = '0;
    loc_adv[L0] = 1'b0;
    loc_adv[L1] = loc[L0] | back_edge;
    loc_adv[L2] = loc[L1];
    loc_adv[L3] = loc[L2] & w_nz;
    loc_adv[L4] = loc[L3];
    loc_adv[L5] = loc[L4] | (loc[L2] & ~w_nz);
    loc_adv[L6] = loc[L5] & x_eq_y;
    loc_adv[L7] = loc[L7] | (loc[L6] & z_nz);
    loc_adv[L8] = loc[L8] | (loc[L6] & ~z_nz);
  end

  // Next-state logic. While the integrity monitor reports a broken
  // encoding, every variable holds. Only the fault-injection XOR still
  // reaches loc in that case, so the test hook can repair the register.
  always_comb begin
    loc_next  = loc ^ inj_loc;
    x_next    = x;
    y_next    = y;
    z_next    = z;
    w_next    = w;
    iter_next = iter_cnt;

    if (onehot_ok) begin
      if (start_ok) begin
        // x and z keep their values across a launch.
        loc_next  = LOC_L0 ^ inj_loc;
        y_next    = y_init;
        w_next    = w_init;
        iter_next = '0;
      end else begin
        loc_next = loc_adv ^ inj_loc;

        if (loc[L1]) begin
          x_next = y;
        end else if (loc[L2] & w_nz) begin
          x_next = x + STEP_W;
        end

        if (loc[L0]) begin
          y_next = y + Y_STEP_W;
        end

        // z priority: L0 clears, then L3 sets, then the back-edge clears.
        if (loc[L0]) begin
          z_next = '0;
        end else if (loc[L3]) begin
          z_next = W'(1);
        end else if (back_edge) begin
          z_next = '0;
        end

        if (back_edge && (iter_cnt != MAX_IT_W)) begin
          iter_next = iter_cnt + ITW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc       <= LOC_IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      w         <= '0;
      iter_cnt  <= '0;
      onehot_ok <= 1'b1;
    end else begin
      onehot_ok <= $onehot(loc);
      loc       <= loc_next;
      x         <= x_next;
      y         <= y_next;
      z         <= z_next;
      w         <= w_next;
      iter_cnt  <= iter_next;
    end
  end

endmodule
